// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - sums N_TERMS products from an external 3x3 multiplier
// Define PRODUCT_ACCUMULATOR_SAT_EN to saturate the accumulator instead of wrapping.
module product_accumulator #(
   parameter int N_TERMS = 4,
   parameter int ACC_W   = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op_a,
   input  logic [2:0]       op_b,
   output logic [2:0]       mul_a,
   output logic [2:0]       mul_b,
   input  logic [5:0]       mul_p,
   output logic [ACC_W-1:0] acc_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             ovf
);
   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [7:0]       term_cnt;
   logic [ACC_W-1:0] acc;
   logic [ACC_W:0]   sum;
   logic             accept;
   logic             release_out;
   logic             last_term;

   // One spare bit on top of the accumulator captures the carry of each add.
   assign sum       = {1'b0, acc} + {{(ACC_W-5){1'b0}}, mul_p};
   assign last_term = (term_cnt == 8'(N_TERMS - 1));
   assign acc_out   = acc;

   always_comb begin
      state_nxt   = state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      accept      = 1'b0;
      release_out = 1'b0;
      case (state)
         IDLE: begin
            in_ready = !reset;
            if (in_valid && !reset) begin
               accept    = 1'b1;
               state_nxt = MUL;
            end
         end
         MUL: begin
            state_nxt = last_term ? DONE : IDLE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               release_out = 1'b1;
               state_nxt   = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mul_a    <= 3'd0;
         mul_b    <= 3'd0;
         acc      <= '0;
         term_cnt <= 8'd0;
         ovf      <= 1'b0;
      end else begin
         if (accept) begin
            mul_a <= op_a;
            mul_b <= op_b;
         end
         if (state == MUL) begin
            term_cnt <= term_cnt + 8'd1;
`ifdef PRODUCT_ACCUMULATOR_SAT_EN
            if (sum[ACC_W]) begin
               acc <= '1;
               ovf <= 1'b1;
            end else begin
               acc <= sum[ACC_W-1:0];
            end
`else
            acc <= sum[ACC_W-1:0];
            if (sum[ACC_W]) begin
               ovf <= 1'b1;
            end
`endif
         end
         if (release_out) begin
            acc      <= '0;
            ovf      <= 1'b0;
            term_cnt <= 8'd0;
         end
      end
   end
endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - scoreboard bench for product_accumulator
// Three instances: defaults, N_TERMS=2/ACC_W=6, and N_TERMS=1.
module tb_product_accumulator;
   typedef struct {
      int inst;
      int acc;
      int ovf;
   } exp_t;

   logic            clk = 1'b0;
   logic [2:0]      rst;
   logic [2:0]      iv;
   logic [2:0]      ir;
   logic [2:0][2:0] oa;
   logic [2:0][2:0] ob;
   logic [2:0][2:0] ma;
   logic [2:0][2:0] mb;
   logic [2:0][5:0] mp;
   logic [2:0][9:0] acc;
   logic [5:0]      acc1;
   logic [2:0]      ov;
   logic [2:0]      ovld;
   logic [2:0]      ordy;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_mul
      assign mp[g] = 6'(ma[g]) * 6'(mb[g]);
   end
   assign acc[1] = {4'b0, acc1};

   product_accumulator u0 (
      .clk(clk), .reset(rst[0]), .in_valid(iv[0]), .in_ready(ir[0]),
      .op_a(oa[0]), .op_b(ob[0]), .mul_a(ma[0]), .mul_b(mb[0]), .mul_p(mp[0]),
      .acc_out(acc[0]), .out_valid(ovld[0]), .out_ready(ordy[0]), .ovf(ov[0])
   );
   product_accumulator #(.N_TERMS(2), .ACC_W(6)) u1 (
      .clk(clk), .reset(rst[1]), .in_valid(iv[1]), .in_ready(ir[1]),
      .op_a(oa[1]), .op_b(ob[1]), .mul_a(ma[1]), .mul_b(mb[1]), .mul_p(mp[1]),
      .acc_out(acc1), .out_valid(ovld[1]), .out_ready(ordy[1]), .ovf(ov[1])
   );
   product_accumulator #(.N_TERMS(1), .ACC_W(10)) u2 (
      .clk(clk), .reset(rst[2]), .in_valid(iv[2]), .in_ready(ir[2]),
      .op_a(oa[2]), .op_b(ob[2]), .mul_a(ma[2]), .mul_b(mb[2]), .mul_p(mp[2]),
      .acc_out(acc[2]), .out_valid(ovld[2]), .out_ready(ordy[2]), .ovf(ov[2])
   );

   task automatic chk(string nm, int act, int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic cyc(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Called just after a rising edge; returns just after the accepting edge (MUL state).
   task automatic send(int k, int a, int b);
      int n = 0;
      iv[k] = 1'b1;
      oa[k] = 3'(a);
      ob[k] = 3'(b);
      @(negedge clk);
      while (!ir[k] && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!ir[k]) chk("accept_timeout", 0, 1);
      @(posedge clk);
      #1;
      iv[k] = 1'b0;
   endtask

   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (ovld[k] && ordy[k] && !rst[k]) begin
            if (sb.size() == 0) begin
               chk("unexpected_result", k, -1);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("result_inst", k, e.inst);
               chk("result_acc", int'(acc[k]), e.acc);
               chk("result_ovf", int'(ov[k]), e.ovf);
            end
         end
      end
   end

   initial begin
      rst  = '1;
      iv   = '0;
      oa   = '0;
      ob   = '0;
      ordy = '0;
      cyc(2);
      @(negedge clk);
      for (int k = 0; k < 3; k++) chk("ready_in_reset", int'(ir[k]), 0);
      cyc(1);
      rst = '0;
      @(negedge clk);
      chk("rst_acc", int'(acc[0]), 0);
      chk("rst_valid", int'(ovld[0]), 0);
      chk("rst_ovf", int'(ov[0]), 0);
      chk("rst_mul_a", int'(ma[0]), 0);
      chk("rst_mul_b", int'(mb[0]), 0);
      chk("rst_ready", int'(ir[0]), 1);
      cyc(1);

      // 15 + 49 + 12 + 0 = 76
      sb.push_back('{0, 76, 0});
      send(0, 3, 5);
      @(negedge clk);
      chk("mul_a_latched", int'(ma[0]), 3);
      chk("mul_b_latched", int'(mb[0]), 5);
      chk("ready_in_mul", int'(ir[0]), 0);
      cyc(1);
      @(negedge clk);
      chk("partial_sum", int'(acc[0]), 15);
      cyc(1);
      send(0, 7, 7);
      send(0, 2, 6);
      send(0, 1, 0);
      @(negedge clk);
      chk("valid_during_mul", int'(ovld[0]), 0);
      cyc(1);
      @(negedge clk);
      chk("valid_after_last_mul", int'(ovld[0]), 1);
      chk("sum_76", int'(acc[0]), 76);
      cyc(1);

      // Back-pressure: result held, no pair accepted.
      iv[0] = 1'b1;
      oa[0] = 3'd4;
      ob[0] = 3'd4;
      repeat (5) begin
         @(negedge clk);
         chk("hold_acc", int'(acc[0]), 76);
         chk("hold_valid", int'(ovld[0]), 1);
         chk("hold_ready", int'(ir[0]), 0);
         chk("hold_mul_a", int'(ma[0]), 1);
         cyc(1);
      end

      // Pair offered in the handshake cycle is taken one cycle later: 6 + 1 + 1 + 1.
      sb.push_back('{0, 9, 0});
      ordy[0] = 1'b1;
      oa[0]   = 3'd2;
      ob[0]   = 3'd3;
      @(negedge clk);
      chk("ready_in_handshake", int'(ir[0]), 0);
      cyc(1);
      @(negedge clk);
      chk("no_accept_in_handshake", int'(ma[0]), 1);
      chk("cleared_acc", int'(acc[0]), 0);
      chk("cleared_valid", int'(ovld[0]), 0);
      chk("ready_after_done", int'(ir[0]), 1);
      cyc(1);
      iv[0] = 1'b0;
      @(negedge clk);
      chk("late_accept_a", int'(ma[0]), 2);
      chk("late_accept_b", int'(mb[0]), 3);
      cyc(1);
      repeat (3) send(0, 1, 1);
      cyc(3);

      // Reset in the MUL cycle of the second term discards the partial sum.
      send(0, 7, 7);
      send(0, 7, 7);
      rst[0] = 1'b1;
      iv[0]  = 1'b1;
      oa[0]  = 3'd5;
      ob[0]  = 3'd5;
      cyc(1);
      @(negedge clk);
      chk("ready_in_reset_idle", int'(ir[0]), 0);
      cyc(1);
      rst[0] = 1'b0;
      iv[0]  = 1'b0;
      @(negedge clk);
      chk("midrst_acc", int'(acc[0]), 0);
      chk("midrst_mul_a", int'(ma[0]), 0);
      chk("midrst_valid", int'(ovld[0]), 0);
      cyc(1);
      sb.push_back('{0, 4, 0});
      repeat (4) send(0, 1, 1);
      cyc(3);

      // Narrow accumulator: 49 + 49 = 98 overflows 6 bits.
      ordy[1] = 1'b1;
`ifdef PRODUCT_ACCUMULATOR_SAT_EN
      sb.push_back('{1, 63, 1});
`else
      sb.push_back('{1, 34, 1});
`endif
      send(1, 7, 7);
      cyc(1);
      @(negedge clk);
      chk("narrow_partial", int'(acc[1]), 49);
      chk("narrow_partial_ovf", int'(ov[1]), 0);
      cyc(1);
      send(1, 7, 7);
      cyc(3);
      sb.push_back('{1, 1, 0});
      send(1, 1, 1);
      send(1, 0, 5);
      cyc(3);

      // Single-term results separated by idle gaps.
      ordy[2] = 1'b1;
      repeat (3) begin
         sb.push_back('{2, 30, 0});
         send(2, 5, 6);
         cyc(2);
         repeat (3) begin
            @(negedge clk);
            chk("idle_no_accum", int'(acc[2]), 0);
            chk("idle_no_valid", int'(ovld[2]), 0);
            cyc(1);
         end
      end

      cyc(4);
      chk("scoreboard_drain", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
